// File: rtl/stream_downsize.sv
// Wide-to-narrow AXI-Stream stage: registers one wide beat, then emits its kept
// lanes one per cycle, lowest lane first, regenerating TLAST on the final kept lane.
module stream_downsize #(
    parameter int T_DATA_WIDTH = 4,
    parameter int T_DATA_RATIO = 2
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [T_DATA_WIDTH-1:0] s_data_i [T_DATA_RATIO],
    input  logic [T_DATA_RATIO-1:0] s_keep_i,
    input  logic                    s_last_i,
    input  logic                    s_valid_i,
    output logic                    s_ready_o,
    output logic [T_DATA_WIDTH-1:0] m_data_o,
    output logic                    m_last_o,
    output logic                    m_valid_o,
    input  logic                    m_ready_i
);

    localparam int SEL_W = $clog2(T_DATA_RATIO);

    // Handshakes: a beat moves on a rising edge where valid && ready are both high;
    // valid never waits on ready, and held output data/last stay stable while stalled.
    typedef enum logic {
        EMPTY = 1'b0,
        DRAIN = 1'b1
    } state_e;

    logic [T_DATA_WIDTH-1:0] data_q [T_DATA_RATIO];
    logic [T_DATA_WIDTH-1:0] data_d [T_DATA_RATIO];
    logic [T_DATA_RATIO-1:0] rem_q;
    logic [T_DATA_RATIO-1:0] rem_d;
    logic                    last_q;
    logic                    last_d;

    state_e                  state;
    logic [SEL_W-1:0]        sel;
    logic                    rem_one_hot;
    logic                    m_hs;
    logic                    s_hs;
    logic                    final_beat;

    // Lowest remaining lane wins; scanning high-to-low leaves the lowest set bit last.
    always_comb begin
        sel = '0;
        for (int i = T_DATA_RATIO - 1; i >= 0; i--) begin
            if (rem_q[i]) begin
                sel = SEL_W'(i);
            end
        end
    end

    always_comb begin
        state       = (rem_q == '0) ? EMPTY : DRAIN;
        rem_one_hot = (rem_q != '0) && ((rem_q & (rem_q - T_DATA_RATIO'(1))) == '0);
        m_valid_o   = (state == DRAIN);
        m_data_o    = data_q[sel];
        m_last_o    = last_q && rem_one_hot;
        m_hs        = m_valid_o && m_ready_i;
        final_beat  = m_hs && rem_one_hot;
        // Ready follows m_ready_i combinationally in the last lane's cycle so
        // consecutive wide beats drain with no idle cycle in between.
        s_ready_o   = !rst_i && ((state == EMPTY) || final_beat);
        s_hs        = s_valid_i && s_ready_o;
    end

    always_comb begin
        data_d = data_q;
        rem_d  = rem_q;
        last_d = last_q;
        if (m_hs) begin
            rem_d[sel] = 1'b0;
        end
        // A new wide beat replaces whatever the final narrow handshake cleared.
        if (s_hs) begin
            data_d = s_data_i;
            rem_d  = s_keep_i;
            last_d = s_last_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < T_DATA_RATIO; i++) begin
                data_q[i] <= '0;
            end
            rem_q  <= '0;
            last_q <= 1'b0;
        end else begin
            data_q <= data_d;
            rem_q  <= rem_d;
            last_q <= last_d;
        end
    end

endmodule

// File: tb/tb_stream_downsize.sv
// Directed bench for stream_downsize: a 2-lane instance for the main scenarios
// and a 4-lane instance for sparse and empty keep masks.
module tb_stream_downsize;

    logic       clk;
    logic       rst;

    logic [3:0] s_data [2];
    logic [1:0] s_keep;
    logic       s_last;
    logic       s_valid;
    logic       s_ready;
    logic [3:0] m_data;
    logic       m_last;
    logic       m_valid;
    logic       m_ready;

    logic [3:0] s4_data [4];
    logic [3:0] s4_keep;
    logic       s4_last;
    logic       s4_valid;
    logic       s4_ready;
    logic [3:0] m4_data;
    logic       m4_last;
    logic       m4_valid;
    logic       m4_ready;

    int n_checks;
    int n_errors;
    logic [3:0] exp_q[$];

    stream_downsize #(.T_DATA_WIDTH(4), .T_DATA_RATIO(2)) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .s_data_i (s_data),
        .s_keep_i (s_keep),
        .s_last_i (s_last),
        .s_valid_i(s_valid),
        .s_ready_o(s_ready),
        .m_data_o (m_data),
        .m_last_o (m_last),
        .m_valid_o(m_valid),
        .m_ready_i(m_ready)
    );

    stream_downsize #(.T_DATA_WIDTH(4), .T_DATA_RATIO(4)) dut4 (
        .clk_i    (clk),
        .rst_i    (rst),
        .s_data_i (s4_data),
        .s_keep_i (s4_keep),
        .s_last_i (s4_last),
        .s_valid_i(s4_valid),
        .s_ready_o(s4_ready),
        .m_data_o (m4_data),
        .m_last_o (m4_last),
        .m_valid_o(m4_valid),
        .m_ready_i(m4_ready)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Inputs change just after the falling edge; outputs are checked 1 time unit later.
    task automatic next_cycle();
        @(negedge clk);
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic drive(input logic [3:0] d1, input logic [3:0] d0, input logic [1:0] keep,
                         input logic last, input logic valid);
        s_data[1] = d1;
        s_data[0] = d0;
        s_keep    = keep;
        s_last    = last;
        s_valid   = valid;
    endtask

    task automatic expect_out(input string tag, input logic v, input logic [3:0] d,
                              input logic l, input logic rdy);
        check({tag, "_valid"}, 32'(m_valid), 32'(v));
        if (v) begin
            check({tag, "_data"}, 32'(m_data), 32'(d));
            check({tag, "_last"}, 32'(m_last), 32'(l));
        end
        check({tag, "_sready"}, 32'(s_ready), 32'(rdy));
    endtask

    initial begin
        int nb;
        n_checks = 0;
        n_errors = 0;
        rst      = 1'b1;
        m_ready  = 1'b1;
        m4_ready = 1'b1;
        drive(4'h0, 4'h0, 2'b00, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) s4_data[i] = 4'h0;
        s4_keep  = 4'h0;
        s4_last  = 1'b0;
        s4_valid = 1'b0;

        // reset
        repeat (2) @(posedge clk);
        next_cycle(); settle();
        check("rst_m_valid", 32'(m_valid), 32'd0);
        check("rst_m_last", 32'(m_last), 32'd0);
        check("rst_m_data", 32'(m_data), 32'd0);
        check("rst_s_ready", 32'(s_ready), 32'd0);
        check("rst_s4_ready", 32'(s4_ready), 32'd0);

        // basic: {B,A} full keep
        next_cycle();
        rst = 1'b0;
        drive(4'hB, 4'hA, 2'b11, 1'b1, 1'b1);
        settle();
        check("rel_s_ready", 32'(s_ready), 32'd1);
        check("rel_m_valid", 32'(m_valid), 32'd0);
        next_cycle(); s_valid = 1'b0; settle();
        expect_out("basic_a", 1'b1, 4'hA, 1'b0, 1'b0);
        next_cycle(); settle();
        expect_out("basic_b", 1'b1, 4'hB, 1'b1, 1'b1);
        next_cycle(); settle();
        expect_out("basic_idle", 1'b0, 4'h0, 1'b0, 1'b1);

        // partial: only lane 1 kept
        drive(4'h7, 4'h5, 2'b10, 1'b1, 1'b1);
        next_cycle(); s_valid = 1'b0; settle();
        expect_out("partial", 1'b1, 4'h7, 1'b1, 1'b1);
        next_cycle(); settle();
        expect_out("partial_idle", 1'b0, 4'h0, 1'b0, 1'b1);

        // back-pressure on lane 0, next beat {D,C} waiting
        drive(4'hB, 4'hA, 2'b11, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            drive(4'hD, 4'hC, 2'b11, 1'b0, 1'b1);
            m_ready = 1'b0;
            settle();
            expect_out("stall_a", 1'b1, 4'hA, 1'b0, 1'b0);
        end
        next_cycle(); m_ready = 1'b1; settle();
        expect_out("resume_a", 1'b1, 4'hA, 1'b0, 1'b0);
        next_cycle(); settle();
        expect_out("resume_b", 1'b1, 4'hB, 1'b1, 1'b1);
        next_cycle(); s_valid = 1'b0; settle();
        expect_out("chain_c", 1'b1, 4'hC, 1'b0, 1'b0);
        next_cycle(); settle();
        expect_out("chain_d", 1'b1, 4'hD, 1'b0, 1'b1);
        next_cycle(); settle();
        expect_out("chain_idle", 1'b0, 4'h0, 1'b0, 1'b1);

        // back-to-back: {1,0},{3,2},{5,4} -> 0..5 continuously
        for (int i = 0; i < 6; i++) exp_q.push_back(4'(i));
        nb = 0;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) next_cycle();
            if (nb < 3) drive(4'(2 * nb + 1), 4'(2 * nb), 2'b11, (nb == 2), 1'b1);
            else        s_valid = 1'b0;
            settle();
            if (i >= 1 && i <= 6) begin
                check("b2b_valid", 32'(m_valid), 32'd1);
                check("b2b_data", 32'(m_data), 32'(exp_q.pop_front()));
                check("b2b_last", 32'(m_last), 32'(i == 6));
            end else begin
                check("b2b_valid_idle", 32'(m_valid), 32'd0);
            end
            check("b2b_s_ready", 32'(s_ready), 32'((i % 2 == 0) || (i == 7)));
            if (s_valid && s_ready) nb++;
        end
        check("b2b_queue_empty", 32'(exp_q.size()), 32'd0);

        // reset in the middle of a drain
        drive(4'h9, 4'h8, 2'b11, 1'b1, 1'b1);
        next_cycle(); s_valid = 1'b0; settle();
        expect_out("rstmid_a", 1'b1, 4'h8, 1'b0, 1'b0);
        next_cycle(); rst = 1'b1; settle();
        check("rstmid_s_ready", 32'(s_ready), 32'd0);
        next_cycle(); settle();
        check("rstmid_m_valid", 32'(m_valid), 32'd0);
        check("rstmid_m_data", 32'(m_data), 32'd0);
        check("rstmid_m_last", 32'(m_last), 32'd0);
        rst = 1'b0;
        settle();
        check("rstmid_rel_ready", 32'(s_ready), 32'd1);
        next_cycle(); settle();
        expect_out("rstmid_after", 1'b0, 4'h0, 1'b0, 1'b1);

        // 4-lane: sparse keep 1010 emits lanes 1 and 3
        s4_data[0] = 4'h1; s4_data[1] = 4'h2; s4_data[2] = 4'h3; s4_data[3] = 4'h4;
        s4_keep = 4'b1010; s4_last = 1'b1; s4_valid = 1'b1;
        settle();
        check("sp_s_ready", 32'(s4_ready), 32'd1);
        next_cycle(); s4_valid = 1'b0; settle();
        check("sp_l1_valid", 32'(m4_valid), 32'd1);
        check("sp_l1_data", 32'(m4_data), 32'h2);
        check("sp_l1_last", 32'(m4_last), 32'd0);
        check("sp_l1_ready", 32'(s4_ready), 32'd0);
        next_cycle(); settle();
        check("sp_l3_valid", 32'(m4_valid), 32'd1);
        check("sp_l3_data", 32'(m4_data), 32'h4);
        check("sp_l3_last", 32'(m4_last), 32'd1);
        check("sp_l3_ready", 32'(s4_ready), 32'd1);
        next_cycle(); settle();
        check("sp_idle_valid", 32'(m4_valid), 32'd0);

        // 4-lane: keep 0000 accepted without output, then a normal beat
        s4_keep = 4'b0000; s4_last = 1'b1; s4_valid = 1'b1;
        settle();
        check("k0_s_ready", 32'(s4_ready), 32'd1);
        next_cycle();
        s4_data[0] = 4'h6; s4_keep = 4'b0001; s4_last = 1'b1; s4_valid = 1'b1;
        settle();
        check("k0_m_valid", 32'(m4_valid), 32'd0);
        check("k0_next_ready", 32'(s4_ready), 32'd1);
        next_cycle(); s4_valid = 1'b0; settle();
        check("k0_after_valid", 32'(m4_valid), 32'd1);
        check("k0_after_data", 32'(m4_data), 32'h6);
        check("k0_after_last", 32'(m4_last), 32'd1);
        next_cycle(); settle();
        check("k0_final_idle", 32'(m4_valid), 32'd0);

        // final report
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
